led_step_tracker: RTL



---
 rtl/led_anim_pkg.sv | 37 +++
 rtl/led_thermo_check.sv | 16 +
 rtl/led_step_tracker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/led_anim_pkg.sv
// Shared LED animation definitions: the 32-step level table and helpers used by
// both the pattern decoder and the step tracker.
package led_anim_pkg;

    localparam int LED_W   = 10;
    localparam int STEP_W  = 5;
    localparam int N_STEPS = 32;

    // Ramp up, ramp down, short ramp up, short ramp down, one dark step.
    localparam logic [3:0] LVL_TBL [0:N_STEPS-1] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
        4'd8, 4'd9, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5,
        4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0
    };

    // Returns {legal, level}; legal only for a left-justified thermometer code.
    function automatic logic [4:0] thermo_level(input logic [LED_W-1:0] led);
        logic [3:0]       n;
        logic [LED_W-1:0] pat;
        n = 4'd0;
        for (int i = 0; i < LED_W; i++) begin
            n = n + 4'(led[i]);
        end
        pat = ~({LED_W{1'b1}} >> n);
        return {(pat == led), n};
    endfunction

    function automatic logic [N_STEPS-1:0] match_mask(input logic [3:0] lvl);
        logic [N_STEPS-1:0] m;
        for (int k = 0; k < N_STEPS; k++) begin
            m[k] = (LVL_TBL[k] == lvl);
        end
        return m;
    endfunction

endpackage

// File: rtl/led_thermo_check.sv
// Combinational legality check and lit-LED count for one LED bar sample.
module led_thermo_check
    import led_anim_pkg::*;
(
    input  logic [LED_W-1:0] led,
    output logic             legal,
    output logic [3:0]       level
);

    logic [4:0] res;

    assign res   = thermo_level(led);
    assign legal = res[4];
    assign level = res[3:0];

endmodule

// File: rtl/led_step_tracker.sv
// Recovers the animation step index from observed LED bar samples using a
// 32-bit candidate mask that advances and narrows on each legal sample.
module led_step_tracker
    import led_anim_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic [LED_W-1:0]     led,
    output logic [3:0]           level,
    output logic [STEP_W-1:0]    step,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic ST_SEARCH = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic [N_STEPS-1:0]   cand_q, cand_d;
    logic [3:0]           level_q, level_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 state_q, state_d;
    logic                 mismatch_q, mismatch_d;
    logic                 illegal_q, illegal_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic                 legal_in;
    logic [3:0]           level_in;
    logic [N_STEPS-1:0]   match_in;
    logic [N_STEPS-1:0]   nxt;
    logic [ERR_CNT_W-1:0] err_inc;

    function automatic logic [5:0] popcnt32(input logic [N_STEPS-1:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < N_STEPS; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [STEP_W-1:0] onehot_idx(input logic [N_STEPS-1:0] v);
        logic [STEP_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_STEPS; i++) begin
            if (v[i]) idx = STEP_W'(i);
        end
        return idx;
    endfunction

    led_thermo_check u_thermo (
        .led   (led),
        .legal (legal_in),
        .level (level_in)
    );

    assign match_in = match_mask(level_in);
    // Every live candidate advances one step (31 wraps to 0) before filtering.
    assign nxt      = {cand_q[N_STEPS-2:0], cand_q[N_STEPS-1]} & match_in;
    assign err_inc  = (err_q == {ERR_CNT_W{1'b1}}) ? err_q
                                                   : err_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        cand_d     = cand_q;
        level_d    = level_q;
        mismatch_d = 1'b0;
        illegal_d  = 1'b0;
        err_d      = err_q;
        if (sample_valid) begin
            if (!legal_in) begin
                illegal_d = 1'b1;
                err_d     = err_inc;
                cand_d    = '1;
            end else begin
                level_d = level_in;
                if (nxt != '0) begin
                    cand_d = nxt;
                end else begin
                    mismatch_d = 1'b1;
                    err_d      = err_inc;
                    cand_d     = match_in;
                end
            end
        end
        state_d = (popcnt32(cand_d) == 6'd1) ? ST_LOCKED : ST_SEARCH;
        step_d  = (state_d == ST_LOCKED) ? onehot_idx(cand_d) : step_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q     <= '1;
            level_q    <= 4'd0;
            step_q     <= '0;
            state_q    <= ST_SEARCH;
            mismatch_q <= 1'b0;
            illegal_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            cand_q     <= cand_d;
            level_q    <= level_d;
            step_q     <= step_d;
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            illegal_q  <= illegal_d;
            err_q      <= err_d;
        end
    end

    assign level    = level_q;
    assign step     = step_q;
    assign locked   = (state_q == ST_LOCKED);
    assign mismatch = mismatch_q;
    assign illegal  = illegal_q;
    assign err_cnt  = err_q;

endmodule
